// File: rtl/rho_rotate_controller.sv
// rho_rotate_controller
// Sequences the Keccak rho step over a 25-lane x 64-slice state memory.
// On start it optionally loads the state file. For each lane 0..24 it then
// reads the lane, rotates it by the fixed rho offset (forward or inverse)
// and writes it back. It optionally saves the state file, then pulses done.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start, inverse  : pass request (sampled in IDLE), direction captured at accept
//   busy, done      : pass in progress / one-cycle completion pulse
//   mem_read/write/load/save : registered memory commands, at most one high
//   mem_idx         : lane index x+5y (0..24)
//   mem_rdata       : lane from memory, valid the cycle after mem_read
//   mem_wdata       : rotated lane, meaningful while mem_write=1
module rho_rotate_controller #(
    parameter bit USE_FILE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        inverse,
    output logic        busy,
    output logic        done,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_load,
    output logic        mem_save,
    output logic [4:0]  mem_idx,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READ, S_ROT, S_WRITE, S_SAVE, S_DONE
    } state_t;

    state_t      state;
    logic [4:0]  i;
    logic        inv_q;
    logic [63:0] lane_q;
    logic [5:0]  amt;
    logic [63:0] rot;

    function automatic logic [5:0] rho_off(input logic [4:0] idx);
        case (idx)
            5'd0:  rho_off = 6'd0;   5'd1:  rho_off = 6'd1;
            5'd2:  rho_off = 6'd62;  5'd3:  rho_off = 6'd28;
            5'd4:  rho_off = 6'd27;  5'd5:  rho_off = 6'd36;
            5'd6:  rho_off = 6'd44;  5'd7:  rho_off = 6'd6;
            5'd8:  rho_off = 6'd55;  5'd9:  rho_off = 6'd20;
            5'd10: rho_off = 6'd3;   5'd11: rho_off = 6'd10;
            5'd12: rho_off = 6'd43;  5'd13: rho_off = 6'd25;
            5'd14: rho_off = 6'd39;  5'd15: rho_off = 6'd41;
            5'd16: rho_off = 6'd45;  5'd17: rho_off = 6'd15;
            5'd18: rho_off = 6'd21;  5'd19: rho_off = 6'd8;
            5'd20: rho_off = 6'd18;  5'd21: rho_off = 6'd2;
            5'd22: rho_off = 6'd61;  5'd23: rho_off = 6'd56;
            5'd24: rho_off = 6'd14;
            default: rho_off = 6'd0;
        endcase
    endfunction

    // Inverse offset is (64 - r) mod 64, which is just the 6-bit negation.
    assign amt = inv_q ? (6'd0 - rho_off(i)) : rho_off(i);

    // Right-rotate by amt with both shifts kept within 0..63. When amt=0 the
    // left shift is also 0 and d|d = d, so no special case is needed.
    assign rot = (mem_rdata >> amt) | (mem_rdata << (6'd0 - amt));

    assign mem_idx   = i;
    assign mem_wdata = lane_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            i         <= 5'd0;
            inv_q     <= 1'b0;
            lane_q    <= 64'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_load  <= 1'b0;
            mem_save  <= 1'b0;
        end else begin
            // Commands and done are single-cycle unless re-asserted below.
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_load  <= 1'b0;
            mem_save  <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i     <= 5'd0;
                        inv_q <= inverse;
                        busy  <= 1'b1;
                        if (USE_FILE) begin
                            state    <= S_LOAD;
                            mem_load <= 1'b1;
                        end else begin
                            state    <= S_READ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    state    <= S_READ;
                    mem_read <= 1'b1;
                end
                S_READ: state <= S_ROT;
                S_ROT: begin
                    lane_q    <= rot;
                    state     <= S_WRITE;
                    mem_write <= 1'b1;
                end
                S_WRITE: begin
                    if (i == 5'd24) begin
                        if (USE_FILE) begin
                            state    <= S_SAVE;
                            mem_save <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        i        <= i + 5'd1;
                        state    <= S_READ;
                        mem_read <= 1'b1;
                    end
                end
                S_SAVE: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rho_rotate_controller.sv
// Self-checking bench for rho_rotate_controller. Two instances are driven:
// dut1 with the load/save phases enabled and dut0 with them skipped, each
// attached to its own behavioural lane memory.
module tb_rho_rotate_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start1, start0, inverse;
    logic busy1, done1, rd1, wr1, ld1, sv1;
    logic busy0, done0, rd0, wr0, ld0, sv0;
    logic [4:0]  idx1, idx0;
    logic [63:0] rdata1 = 64'd0, rdata0 = 64'd0, wdata1, wdata0;

    logic [63:0] mem1 [25];
    logic [63:0] mem0 [25];
    logic [63:0] expm [25];
    logic [63:0] orig [25];

    int R [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                   41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    int pass_cnt = 0;
    int total    = 0;

    // statistics of the most recent run
    int done_at, done_last, n_done, n_load, load_at, n_save, save_at;
    int overlap, busy_bad;
    int rcnt [25];
    int wcnt [25];

    rho_rotate_controller #(.USE_FILE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .inverse(inverse),
        .busy(busy1), .done(done1), .mem_read(rd1), .mem_write(wr1),
        .mem_load(ld1), .mem_save(sv1), .mem_idx(idx1),
        .mem_rdata(rdata1), .mem_wdata(wdata1)
    );

    rho_rotate_controller #(.USE_FILE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .inverse(inverse),
        .busy(busy0), .done(done0), .mem_read(rd0), .mem_write(wr0),
        .mem_load(ld0), .mem_save(sv0), .mem_idx(idx0),
        .mem_rdata(rdata0), .mem_wdata(wdata0)
    );

    // Lane memories: read data returned the cycle after mem_read.
    always @(posedge clk) begin
        if (rd1) rdata1 <= mem1[idx1];
        if (wr1) mem1[idx1] = wdata1;
        if (rd0) rdata0 <= mem0[idx0];
        if (wr0) mem0[idx0] = wdata0;
    end

    // Reference rotation from the slice definition: out slice z takes
    // in slice (z - r) mod 64, slice z living at bit 63-z.
    function automatic logic [63:0] rho_ref(input logic [63:0] d, input int r);
        logic [63:0] o;
        for (int z = 0; z < 64; z++) o[63 - z] = d[63 - ((z - r + 64) % 64)];
        return o;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Runs one pass on the selected instance for max cycles, gathering
    // statistics. mode 0: plain, 1: noisy start/inverse while busy,
    // 2: start held until the second pass has been accepted.
    task automatic run(input bit which, input logic inv, input int lat,
                       input int max, input int mode);
        logic b, d, r, w, l, s;
        logic [4:0] x;
        done_at = 0; done_last = 0; n_done = 0; n_load = 0; load_at = 0;
        n_save = 0; save_at = 0; overlap = 0; busy_bad = 0;
        for (int k = 0; k < 25; k++) begin rcnt[k] = 0; wcnt[k] = 0; end
        inverse = inv;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        if (mode != 2) begin start1 = 1'b0; start0 = 1'b0; end
        for (int c = 1; c <= max; c++) begin
            if (which) begin
                b = busy1; d = done1; r = rd1; w = wr1; l = ld1; s = sv1; x = idx1;
            end else begin
                b = busy0; d = done0; r = rd0; w = wr0; l = ld0; s = sv0; x = idx0;
            end
            if (l) begin n_load++; load_at = c; end
            if (s) begin n_save++; save_at = c; end
            if (r && x < 25) rcnt[x]++;
            if (w && x < 25) wcnt[x]++;
            if (int'(r) + int'(w) + int'(l) + int'(s) > 1) overlap++;
            if (mode != 2 && b !== (c < lat)) busy_bad++;
            if (d) begin n_done++; if (done_at == 0) done_at = c; done_last = c; end
            if (mode == 1 && c >= 3 && c <= 70) begin
                start1 = 1'($urandom); start0 = 1'($urandom); inverse = 1'($urandom);
            end else if (mode == 2 && c == 80) begin
                start1 = 1'b0; start0 = 1'b0;
            end else if (mode != 2) begin
                start1 = 1'b0; start0 = 1'b0;
            end
            @(posedge clk); #1;
        end
        start1 = 1'b0; start0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b1; start0 = 1'b1; inverse = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy1, done1, rd1, wr1, ld1, sv1, idx1, wdata1} !== 75'd0) begin
            $display("FAIL reset_dut1 got %h want 0", {busy1, done1, rd1, wr1, ld1, sv1, idx1, wdata1});
        end else pass_cnt++;
        total++;
        if ({busy0, done0, rd0, wr0, ld0, sv0, idx0, wdata0} !== 75'd0) begin
            $display("FAIL reset_dut0 got %h want 0", {busy0, done0, rd0, wr0, ld0, sv0, idx0, wdata0});
        end else pass_cnt++;
        start1 = 1'b0; start0 = 1'b0; inverse = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy1 !== 1'b0 || rd1 !== 1'b0 || ld1 !== 1'b0) begin
            $display("FAIL reset_start_wins busy=%b rd=%b ld=%b want 0", busy1, rd1, ld1);
        end else pass_cnt++;
    endtask

    task automatic test_forward_single();
        for (int k = 0; k < 25; k++) mem1[k] = rnd64();
        mem1[1] = 64'h8000_0000_0000_0000;
        mem1[2] = 64'h8000_0000_0000_0000;
        for (int k = 0; k < 25; k++) begin
            orig[k] = mem1[k];
            expm[k] = rho_ref(mem1[k], R[k]);
        end
        run(1'b1, 1'b0, 78, 90, 0);
        total++;
        if (mem1[1] !== 64'h4000_0000_0000_0000) begin
            $display("FAIL fwd_lane1 got %h want 4000000000000000", mem1[1]);
        end else pass_cnt++;
        total++;
        if (mem1[2] !== 64'h0000_0000_0000_0002) begin
            $display("FAIL fwd_lane2 got %h want 0000000000000002", mem1[2]);
        end else pass_cnt++;
        total++;
        if (mem1[0] !== orig[0]) begin
            $display("FAIL fwd_lane0_identity got %h want %h", mem1[0], orig[0]);
        end else pass_cnt++;
        for (int k = 0; k < 25; k++) begin
            total++;
            if (mem1[k] !== expm[k]) begin
                $display("FAIL fwd_lane%0d got %h want %h", k, mem1[k], expm[k]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_sequencing();
        bit walk_ok;
        for (int k = 0; k < 25; k++) mem1[k] = rnd64();
        run(1'b1, 1'($urandom), 78, 95, 0);
        total++;
        if (done_at !== 78 || n_done !== 1) begin
            $display("FAIL seq_done got cycle %0d count %0d want cycle 78 count 1", done_at, n_done);
        end else pass_cnt++;
        total++;
        if (n_load !== 1 || load_at !== 1) begin
            $display("FAIL seq_load got count %0d at %0d want 1 at 1", n_load, load_at);
        end else pass_cnt++;
        total++;
        if (n_save !== 1 || save_at !== 77) begin
            $display("FAIL seq_save got count %0d at %0d want 1 at 77", n_save, save_at);
        end else pass_cnt++;
        walk_ok = 1'b1;
        for (int k = 0; k < 25; k++) if (rcnt[k] != 1 || wcnt[k] != 1) walk_ok = 1'b0;
        total++;
        if (!walk_ok) begin
            $display("FAIL seq_idx_walk got uneven read/write counts want one each for 0..24");
        end else pass_cnt++;
        total++;
        if (overlap !== 0) begin
            $display("FAIL seq_one_hot got %0d overlapping cycles want 0", overlap);
        end else pass_cnt++;
        total++;
        if (busy_bad !== 0) begin
            $display("FAIL seq_busy got %0d wrong cycles want 0", busy_bad);
        end else pass_cnt++;
    endtask

    task automatic test_round_trip();
        for (int k = 0; k < 25; k++) begin mem1[k] = rnd64(); orig[k] = mem1[k]; end
        run(1'b1, 1'b0, 78, 85, 0);
        total++;
        if (mem1[0] !== orig[0]) begin
            $display("FAIL rt_lane0_after_fwd got %h want %h", mem1[0], orig[0]);
        end else pass_cnt++;
        run(1'b1, 1'b1, 78, 85, 0);
        for (int k = 0; k < 25; k++) begin
            total++;
            if (mem1[k] !== orig[k]) begin
                $display("FAIL rt_lane%0d got %h want %h", k, mem1[k], orig[k]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_no_file();
        for (int k = 0; k < 25; k++) begin
            mem0[k] = rnd64();
            expm[k] = rho_ref(mem0[k], (64 - R[k]) % 64);
        end
        run(1'b0, 1'b1, 76, 90, 0);
        total++;
        if (done_at !== 76 || n_done !== 1) begin
            $display("FAIL nofile_done got cycle %0d count %0d want cycle 76 count 1", done_at, n_done);
        end else pass_cnt++;
        total++;
        if (n_load !== 0 || n_save !== 0) begin
            $display("FAIL nofile_load_save got %0d/%0d want 0/0", n_load, n_save);
        end else pass_cnt++;
        total++;
        if (busy_bad !== 0 || overlap !== 0) begin
            $display("FAIL nofile_busy got %0d bad busy %0d overlap want 0", busy_bad, overlap);
        end else pass_cnt++;
        for (int k = 0; k < 25; k++) begin
            total++;
            if (mem0[k] !== expm[k]) begin
                $display("FAIL nofile_lane%0d got %h want %h", k, mem0[k], expm[k]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        int stray;
        for (int k = 0; k < 25; k++) begin
            mem1[k] = rnd64(); orig[k] = mem1[k];
            expm[k] = rho_ref(mem1[k], R[k]);
        end
        inverse = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (wr1 && idx1 == 5'd10) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (!found) begin
            $display("FAIL midrst_reach_lane10 got timeout want WRITE of lane 10");
        end else pass_cnt++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({busy1, done1, rd1, wr1, ld1, sv1, idx1, wdata1} !== 75'd0) begin
            $display("FAIL midrst_outputs got %h want 0", {busy1, done1, rd1, wr1, ld1, sv1, idx1, wdata1});
        end else pass_cnt++;
        stray = 0;
        for (int c = 0; c < 90; c++) begin
            if (done1 || sv1 || busy1) stray++;
            @(posedge clk); #1;
        end
        total++;
        if (stray !== 0) begin
            $display("FAIL midrst_no_done_save got %0d active cycles want 0", stray);
        end else pass_cnt++;
        for (int k = 0; k < 25; k++) begin
            if (k == 10) continue;
            total++;
            if (k < 10 && mem1[k] !== expm[k]) begin
                $display("FAIL midrst_lane%0d got %h want rotated %h", k, mem1[k], expm[k]);
            end else if (k > 10 && mem1[k] !== orig[k]) begin
                $display("FAIL midrst_lane%0d got %h want untouched %h", k, mem1[k], orig[k]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_busy_start();
        logic inv0;
        inv0 = 1'($urandom);
        for (int k = 0; k < 25; k++) begin
            mem1[k] = rnd64();
            expm[k] = inv0 ? rho_ref(mem1[k], (64 - R[k]) % 64) : rho_ref(mem1[k], R[k]);
        end
        run(1'b1, inv0, 78, 110, 1);
        total++;
        if (n_done !== 1 || done_at !== 78) begin
            $display("FAIL busy_single_done got count %0d at %0d want 1 at 78", n_done, done_at);
        end else pass_cnt++;
        for (int k = 0; k < 25; k++) begin
            total++;
            if (mem1[k] !== expm[k]) begin
                $display("FAIL busy_lane%0d got %h want %h", k, mem1[k], expm[k]);
            end else pass_cnt++;
        end
        inverse = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 25; k++) begin
            mem1[k] = rnd64();
            expm[k] = rho_ref(rho_ref(mem1[k], R[k]), R[k]);
        end
        run(1'b1, 1'b0, 78, 170, 2);
        total++;
        if (n_done !== 2 || done_at !== 78 || done_last !== 157) begin
            $display("FAIL b2b_done got count %0d at %0d,%0d want 2 at 78,157", n_done, done_at, done_last);
        end else pass_cnt++;
        total++;
        if (n_load !== 2 || load_at !== 80) begin
            $display("FAIL b2b_second_load got count %0d last at %0d want 2 last at 80", n_load, load_at);
        end else pass_cnt++;
        for (int k = 0; k < 25; k++) begin
            total++;
            if (mem1[k] !== expm[k]) begin
                $display("FAIL b2b_lane%0d got %h want %h", k, mem1[k], expm[k]);
            end else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start0 = 1'b0; inverse = 1'b0;
        for (int k = 0; k < 25; k++) begin mem1[k] = 64'd0; mem0[k] = 64'd0; end
        test_reset();
        test_forward_single();
        test_sequencing();
        test_round_trip();
        test_no_file();
        test_mid_reset();
        test_busy_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/rho_rotate_controller.md
# rho_rotate_controller

Sequencer that runs the Keccak rho (lane-rotation) step over the 25-lane × 64-slice state memory of the rotate stage. On `start` it optionally loads the state file, then for each lane index 0..24 reads the lane, rotates it by the fixed rho offset (forward for encode, inverse for decode), and writes it back. It optionally saves the state file and then pulses `done`. It drives the lane-addressed memory's read/write/load/save/idx controls and is the only master of that memory while busy.

## Interface
- `USE_FILE`, default 1: 1 = issue the LOAD and SAVE phases. 0 = skip both; the state is already resident.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request one full rho pass; sampled only in IDLE.
- `inverse` in 1: 0 = forward rho, 1 = inverse rho; captured when `start` is accepted.
- `busy` out 1: high from the first cycle after acceptance through the cycle before DONE.
- `done` out 1: one-cycle pulse when the pass completes.
- `mem_read`, `mem_write`, `mem_load`, `mem_save` out 1 each: memory commands, registered.
- `mem_idx` out 5: lane index, x+5y, range 0..24.
- `mem_rdata` in 64: lane from memory; bit 63-z holds slice z. Valid the cycle after `mem_read`.
- `mem_wdata` out 64: rotated lane to memory, same bit order.

## Operation
- States: IDLE, LOAD, READ, ROT, WRITE, SAVE, DONE.
- IDLE:
  - `start`=1 → LOAD if `USE_FILE`=1, else READ.
  - On acceptance: lane counter i ← 0, `inv_q` ← `inverse`.
- LOAD: `mem_load`=1 for one cycle → READ.
- READ: `mem_read`=1, `mem_idx`=i → ROT.
- ROT:
  - Compute `lane_q` ← rot(`mem_rdata`, i).
  - No memory command; `mem_idx` holds i.
  - → WRITE.
- WRITE:
  - `mem_write`=1, `mem_idx`=i, `mem_wdata`=`lane_q`.
  - If i=24 → SAVE (if `USE_FILE`=1) or DONE.
  - Else i ← i+1 → READ.
- SAVE: `mem_save`=1 for one cycle → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Rho offsets r[i], listed for i=0..24: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
- Rotation width rules:
  - Forward: out slice z = in slice (z − r) mod 64, i.e. `lane_q` = (`mem_rdata` >> r) | (`mem_rdata` << (64−r)).
  - Inverse: use r' = (64 − r) mod 64. r=0 gives an identity rotation in both modes.
  - The shift amount is 6 bits; no out-of-range shifts.
- Lane 0 (r=0) still gets the full READ/ROT/WRITE sequence, so cycle count is uniform.
- At most one of `mem_read/write/load/save` is high in any cycle.
- `mem_wdata` equals `lane_q` at all times and is only meaningful when `mem_write`=1.

## Timing
- Reset values: state=IDLE, i=0, `inv_q`=0, `lane_q`=0. All outputs 0: `busy`, `done`, all `mem_*` commands, `mem_idx`=0, `mem_wdata`=0.
- `start` sampled at edge E0. The first command cycle (LOAD or READ) is E0+1.
- Per lane: 3 cycles. Pass latency from E0 to `done`:
  - `USE_FILE`=1: 78 cycles (LOAD 1 + 75 + SAVE 1, then DONE).
  - `USE_FILE`=0: 76 cycles.
- `start` while not IDLE is ignored; no queuing. `start` held high across DONE → IDLE starts a new pass one cycle after DONE.
- `inverse` changes while busy have no effect.
- `rst` in any state returns to IDLE on the next edge and drops every command that cycle. A partial pass is abandoned: lanes already written stay rotated, no SAVE is issued, no `done`.
- `rst` together with `start` → reset wins.

## Test plan
- Forward, single lane: preload lane 1 = 0x8000_0000_0000_0000, `inverse`=0 → WRITE for idx 1 carries 0x4000_0000_0000_0000. Lane 2 with the same value → 0x0000_0000_0000_0002 (r=62).
- Inverse round trip: random 25-lane state, forward pass then inverse pass → memory equals the original state bit-exact. Lane 0 is unchanged after the forward pass alone.
- Sequencing/latency, `USE_FILE`=1:
  - `done` exactly 78 cycles after the start edge.
  - `mem_load` once at +1, `mem_save` once at +77.
  - `mem_idx` walks 0..24, each value seen in exactly one READ and one WRITE.
  - No two commands asserted together.
- `USE_FILE`=0: `done` at +76. `mem_load` and `mem_save` never asserted.
- Mid-pass reset:
  - Assert `rst` during the WRITE of lane 10 → next cycle IDLE, all outputs 0, no `done`, no SAVE.
  - Lanes 0..9 are rotated. Lane 10 is rotated only if its WRITE edge preceded `rst`.
- Busy handling: pulse `start` repeatedly during a pass, and toggle `inverse` → exactly one `done` per accepted start; rotation direction matches the value captured at acceptance.
